// File: rtl/jk_excitation_driver.sv
// jk_excitation_driver: drive side of a JK flip-flop interface.
// Targets (desired next q) arrive over valid/ready, are buffered in a FIFO,
// converted to a J/K excitation from a tracked model state, driven for one
// cycle, and the returned q is checked against the target.
// Optional build macro: JK_TOGGLE_DRIVE_EN selects toggle encoding (j=k=1 for
// every state change) instead of the default set/reset encoding.
module jk_excitation_driver #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tgt_valid,
    input  logic       tgt_bit,
    output logic       tgt_ready,
    output logic       j,
    output logic       k,
    input  logic       q_fb,
    output logic       busy,
    output logic       err,
    output logic [7:0] err_count,
    output logic [7:0] done_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [DEPTH-1:0] mem_r;
    logic [PTR_W:0]   wr_ptr_r;
    logic [PTR_W:0]   rd_ptr_r;
    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic             head_s;
    logic [1:0]       exc_s;
    logic             mism_s;
    logic             tgt_r;
    logic             qm_r;
    logic             j_r;
    logic             k_r;
    logic             err_r;
    logic [7:0]       err_count_r;
    logic [7:0]       done_count_r;

    // J/K excitation {j,k} that moves a flip-flop from state qm to target t.
    function automatic logic [1:0] excite(input logic qm, input logic t);
        logic [1:0] jk;
`ifdef JK_TOGGLE_DRIVE_EN
        if (qm != t) begin
            jk = 2'b11;
        end else begin
            jk = 2'b00;
        end
`else
        case ({qm, t})
            2'b01:   jk = 2'b10;
            2'b10:   jk = 2'b01;
            default: jk = 2'b00;
        endcase
`endif
        return jk;
    endfunction

    // The extra pointer MSB distinguishes full from empty when the index bits match.
    assign full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                     (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign push_s  = tgt_valid && !full_s;
    assign pop_s   = (state_r == ST_IDLE) && !empty_s;
    assign head_s  = mem_r[rd_ptr_r[PTR_W-1:0]];
    assign exc_s   = excite(qm_r, head_s);
    assign mism_s  = (q_fb != tgt_r);

    assign tgt_ready  = !full_s;
    assign busy       = (state_r != ST_IDLE) || !empty_s;
    assign j          = j_r;
    assign k          = k_r;
    assign err        = err_r;
    assign err_count  = err_count_r;
    assign done_count = done_count_r;

    // FIFO storage and pointers; push and pop may share a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_r    <= {DEPTH{1'b0}};
            wr_ptr_r <= {(PTR_W + 1){1'b0}};
            rd_ptr_r <= {(PTR_W + 1){1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r[PTR_W-1:0]] <= tgt_bit;
                wr_ptr_r <= wr_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state: pop when idle with data, drive one cycle, check one cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    next_state_s = ST_DRIVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRIVE: next_state_s = ST_CHECK;
            ST_CHECK: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Drive registers, model state and result counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tgt_r        <= 1'b0;
            qm_r         <= 1'b0;
            j_r          <= 1'b0;
            k_r          <= 1'b0;
            err_r        <= 1'b0;
            err_count_r  <= 8'd0;
            done_count_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        tgt_r <= head_s;
                        j_r   <= exc_s[1];
                        k_r   <= exc_s[0];
                    end else begin
                        j_r   <= 1'b0;
                        k_r   <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    j_r <= 1'b0;
                    k_r <= 1'b0;
                end
                ST_CHECK: begin
                    if (mism_s) begin
                        err_r <= 1'b1;
                        if (err_count_r != 8'hFF) begin
                            err_count_r <= err_count_r + 8'd1;
                        end else begin
                            err_count_r <= err_count_r;
                        end
                    end else begin
                        err_r <= err_r;
                    end
                    done_count_r <= done_count_r + 8'd1;
                    // Follow the real device so later excitations stay correct.
                    qm_r <= q_fb;
                end
                default: begin
                    j_r <= 1'b0;
                    k_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench for jk_excitation_driver with a behavioural JK flip-flop
// on the drive side and a scoreboard of expected per-target results.
module tb_jk_excitation_driver;

    logic       clk;
    logic       rst;
    logic       tgt_valid;
    logic       tgt_bit;
    logic       tgt_ready;
    logic       j;
    logic       k;
    logic       q_fb;
    logic       busy;
    logic       err;
    logic [7:0] err_count;
    logic [7:0] done_count;

    logic       ff_q;
    logic       stuck;

    int tests;
    int failed;

    // Scoreboard entry: {jk[1:0], err, q, err_count[7:0], done_count[7:0]}
    logic [19:0] exp_q[$];
    logic [19:0] obs_v[64];
    int          obs_n;
    int          rd_i;
    int          nz_cnt;
    int          both_cnt;
    logic [1:0]  jk_h1;
    logic [1:0]  jk_h2;
    logic [7:0]  dc_prev;

    // Reference model state
    logic       m_qm;
    logic       m_err;
    logic [7:0] m_ec;
    logic [7:0] m_dc;

    jk_excitation_driver #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .tgt_valid  (tgt_valid),
        .tgt_bit    (tgt_bit),
        .tgt_ready  (tgt_ready),
        .j          (j),
        .k          (k),
        .q_fb       (q_fb),
        .busy       (busy),
        .err        (err),
        .err_count  (err_count),
        .done_count (done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural downstream JK flip-flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff_q <= 1'b0;
        else begin
            case ({j, k})
                2'b10:   ff_q <= 1'b1;
                2'b01:   ff_q <= 1'b0;
                2'b11:   ff_q <= ~ff_q;
                default: ff_q <= ff_q;
            endcase
        end
    end

    assign q_fb = stuck ? 1'b0 : ff_q;

    // Monitor: records the DRIVE-cycle j/k (two samples before a completion)
    always @(negedge clk) begin
        if (!rst) begin
            jk_h1   = 2'b00;
            jk_h2   = 2'b00;
            dc_prev = done_count;
        end else begin
            if (done_count != dc_prev && obs_n < 64) begin
                obs_v[obs_n] = {jk_h2, err, q_fb, err_count, done_count};
                obs_n = obs_n + 1;
            end
            if (j | k) nz_cnt = nz_cnt + 1;
            if (j & k) both_cnt = both_cnt + 1;
            jk_h2   = jk_h1;
            jk_h1   = {j, k};
            dc_prev = done_count;
        end
    end

    function automatic logic [1:0] exp_jk(input logic qm, input logic t);
        logic [1:0] r;
`ifdef JK_TOGGLE_DRIVE_EN
        r = (qm != t) ? 2'b11 : 2'b00;
`else
        if (!qm && t)      r = 2'b10;
        else if (qm && !t) r = 2'b01;
        else               r = 2'b00;
`endif
        return r;
    endfunction

    task automatic push_exp(input logic t);
        logic [1:0] jk;
        logic       qd;
        jk = exp_jk(m_qm, t);
        qd = stuck ? 1'b0 : t;
        if (qd != t) begin
            m_err = 1'b1;
            if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        end
        m_dc = m_dc + 8'd1;
        m_qm = qd;
        exp_q.push_back({jk, m_err, qd, m_ec, m_dc});
    endtask

    task automatic model_reset();
        m_qm = 1'b0; m_err = 1'b0; m_ec = 8'd0; m_dc = 8'd0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        tgt_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rd_i = obs_n;
        rst = 1'b1;
    endtask

    // Called at a negedge; returns at a negedge after the push edge.
    task automatic push_bit(input logic b);
        int w;
        w = 0;
        tgt_valid = 1'b1;
        tgt_bit   = b;
        while (!tgt_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        push_exp(b);
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    task automatic wait_obs(input int n, output bit to);
        int w;
        w = 0;
        while (obs_n < n && w < 200) begin
            @(negedge clk);
            w++;
        end
        to = (obs_n < n);
    endtask

    task automatic test_reset();
        tests++;
        if ({j, k, tgt_ready, busy, err} !== 5'b00100 || err_count !== 8'd0 || done_count !== 8'd0) begin
            failed++;
            $display("FAIL reset_held: j,k,rdy,busy,err=%b ec=%0d dc=%0d required 00100 0 0",
                     {j, k, tgt_ready, busy, err}, err_count, done_count);
        end
        @(negedge clk);
        rd_i = obs_n;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if ({j, k, tgt_ready, busy, err} !== 5'b00100 || err_count !== 8'd0 || done_count !== 8'd0) begin
            failed++;
            $display("FAIL reset_released: j,k,rdy,busy,err=%b ec=%0d dc=%0d required 00100 0 0",
                     {j, k, tgt_ready, busy, err}, err_count, done_count);
        end
    endtask

    task automatic test_single();
        int         nz0;
        bit         to;
        logic [19:0] e;
        logic [1:0]  ejk;
        nz0 = nz_cnt;
        ejk = exp_jk(1'b0, 1'b1);
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        push_exp(1'b1);
        @(negedge clk);                 // push edge passed
        tgt_valid = 1'b0;
        @(negedge clk);                 // E0 passed: DRIVE
        tests++;
        if ({j, k} !== ejk) begin
            failed++; $display("FAIL single_drive_jk: got %b required %b", {j, k}, ejk);
        end
        @(negedge clk);                 // E1 passed: CHECK
        tests++;
        if ({j, k} !== 2'b00 || done_count !== 8'd0) begin
            failed++; $display("FAIL single_check_cycle: jk=%b dc=%0d required 00 0", {j, k}, done_count);
        end
        @(negedge clk);                 // E2 passed
        tests++;
        if (done_count !== 8'd1 || busy !== 1'b0 || q_fb !== 1'b1 || err !== 1'b0) begin
            failed++;
            $display("FAIL single_done: dc=%0d busy=%b q=%b err=%b required 1 0 1 0", done_count, busy, q_fb, err);
        end
        wait_obs(rd_i + 1, to);
        tests++;
        if (to) begin failed++; $display("FAIL single_timeout: got %0d results required %0d", obs_n - rd_i, 1); end
        while (exp_q.size() > 0 && rd_i < obs_n) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_v[rd_i] !== e) begin
                failed++; $display("FAIL single_sb[%0d]: got %h required %h", rd_i, obs_v[rd_i], e);
            end
            rd_i++;
        end
        tests++;
        if (nz_cnt - nz0 !== 1) begin
            failed++; $display("FAIL single_drive_cycles: got %0d required 1", nz_cnt - nz0);
        end
    endtask

    task automatic test_sequence();
        logic [3:0]  seq;
        bit          to;
        logic [19:0] e;
        seq = 4'b0011;                  // applied LSB first: 1,1,0,0
        do_reset();
        for (int i = 0; i < 4; i++) push_bit(seq[i]);
        wait_obs(rd_i + 4, to);
        tests++;
        if (to) begin failed++; $display("FAIL seq_timeout: got %0d results required 4", obs_n - rd_i); end
        while (exp_q.size() > 0 && rd_i < obs_n) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_v[rd_i] !== e) begin
                failed++; $display("FAIL seq_sb[%0d]: got %h required %h", rd_i, obs_v[rd_i], e);
            end
            rd_i++;
        end
        tests++;
        if (done_count !== 8'd4 || err !== 1'b0 || q_fb !== 1'b0) begin
            failed++; $display("FAIL seq_final: dc=%0d err=%b q=%b required 4 0 0", done_count, err, q_fb);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  seq;
        int          i;
        int          cyc;
        bit          saw_full;
        bit          to;
        logic [19:0] e;
        int          both0;
        seq = 8'b0101_0101;             // LSB first: 1,0,1,0,1,0,1,0
        do_reset();
        both0 = both_cnt;
        saw_full = 1'b0;
        i = 0;
        cyc = 0;
        while (i < 8 && cyc < 200) begin
            tgt_valid = 1'b1;
            tgt_bit   = seq[i];
            if (tgt_ready) begin
                push_exp(seq[i]);
                i++;
            end else begin
                saw_full = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        tgt_valid = 1'b0;
        tests++;
        if (saw_full !== 1'b1) begin
            failed++; $display("FAIL b2b_ready_drop: got %b required 1", saw_full);
        end
        wait_obs(rd_i + 8, to);
        tests++;
        if (to) begin failed++; $display("FAIL b2b_timeout: got %0d results required 8", obs_n - rd_i); end
        while (exp_q.size() > 0 && rd_i < obs_n) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_v[rd_i] !== e) begin
                failed++; $display("FAIL b2b_sb[%0d]: got %h required %h", rd_i, obs_v[rd_i], e);
            end
            rd_i++;
        end
        repeat (4) @(negedge clk);
        tests++;
        if (done_count !== 8'd8 || err !== 1'b0 || busy !== 1'b0) begin
            failed++; $display("FAIL b2b_final: dc=%0d err=%b busy=%b required 8 0 0", done_count, err, busy);
        end
`ifndef JK_TOGGLE_DRIVE_EN
        tests++;
        if (both_cnt - both0 !== 0) begin
            failed++; $display("FAIL b2b_jk_both_high: got %0d cycles required 0", both_cnt - both0);
        end
`endif
    endtask

    task automatic test_stuck_fault();
        bit          to;
        logic [19:0] e;
        do_reset();
        stuck = 1'b1;
        push_bit(1'b1);
        wait_obs(rd_i + 1, to);
        push_bit(1'b0);
        wait_obs(rd_i + 2, to);
        tests++;
        if (to) begin failed++; $display("FAIL stuck_timeout: got %0d results required 2", obs_n - rd_i); end
        while (exp_q.size() > 0 && rd_i < obs_n) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_v[rd_i] !== e) begin
                failed++; $display("FAIL stuck_sb[%0d]: got %h required %h", rd_i, obs_v[rd_i], e);
            end
            rd_i++;
        end
        tests++;
        if (err !== 1'b1 || err_count !== 8'd1 || done_count !== 8'd2) begin
            failed++; $display("FAIL stuck_final: err=%b ec=%0d dc=%0d required 1 1 2", err, err_count, done_count);
        end
        stuck = 1'b0;
    endtask

    task automatic test_reset_in_drive();
        bit          to;
        logic [19:0] e;
        logic [1:0]  ejk;
        int          nz0;
        do_reset();
        ejk = exp_jk(1'b0, 1'b1);
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        @(posedge clk);                 // E0: enter DRIVE
        #2;
        tests++;
        if ({j, k} !== ejk) begin
            failed++; $display("FAIL rst_drive_pre: jk=%b required %b", {j, k}, ejk);
        end
        rst = 1'b0;
        #1;
        tests++;
        if ({j, k, tgt_ready, busy} !== 4'b0010 || done_count !== 8'd0) begin
            failed++;
            $display("FAIL rst_drive_async: j,k,rdy,busy=%b dc=%0d required 0010 0", {j, k, tgt_ready, busy}, done_count);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rd_i = obs_n;
        rst = 1'b1;
        @(negedge clk);
        nz0 = nz_cnt;
        push_bit(1'b1);
        wait_obs(rd_i + 1, to);
        tests++;
        if (to) begin failed++; $display("FAIL rst_after_timeout: got %0d results required 1", obs_n - rd_i); end
        while (exp_q.size() > 0 && rd_i < obs_n) begin
            e = exp_q.pop_front();
            tests++;
            if (obs_v[rd_i] !== e) begin
                failed++; $display("FAIL rst_after_sb[%0d]: got %h required %h", rd_i, obs_v[rd_i], e);
            end
            rd_i++;
        end
        @(negedge clk);
        tests++;
        if (done_count !== 8'd1 || busy !== 1'b0 || err !== 1'b0 || nz_cnt - nz0 !== 1) begin
            failed++;
            $display("FAIL rst_after_final: dc=%0d busy=%b err=%b drives=%0d required 1 0 0 1",
                     done_count, busy, err, nz_cnt - nz0);
        end
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        obs_n     = 0;
        rd_i      = 0;
        nz_cnt    = 0;
        both_cnt  = 0;
        jk_h1     = 2'b00;
        jk_h2     = 2'b00;
        dc_prev   = 8'd0;
        stuck     = 1'b0;
        rst       = 1'b0;
        tgt_valid = 1'b0;
        tgt_bit   = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        test_sequence();
        test_back_to_back();
        test_stuck_fault();
        test_reset_in_drive();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/jk_excitation_driver.md
Name: jk_excitation_driver

Overview:
Drive side of the JK flip-flop interface. Accepts a stream of target next-state bits over a valid/ready handshake and buffers them in a small FIFO. For each target it computes the J/K excitation from a tracked model state, drives one downstream JK flip-flop, then reads back its q. Any mismatch is flagged and counted; used as self-checking stimulus for JK-based sequential cells.

Parameters:
DEPTH, 4, FIFO entries; must be a power of 2, minimum 2
PTR_W, 2, FIFO pointer width, log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset
tgt_valid  input  1  target bit offered
tgt_bit  input  1  desired next q of the downstream flip-flop
tgt_ready  output  1  FIFO can accept (= not full)
j  output  1  J drive to the downstream flip-flop (registered)
k  output  1  K drive to the downstream flip-flop (registered)
q_fb  input  1  q returned from the downstream flip-flop
busy  output  1  FSM not IDLE, or FIFO not empty
err  output  1  sticky mismatch flag
err_count  output  8  mismatch count, saturates at 255
done_count  output  8  completed targets, wraps at 255->0

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, FIFO empty, model state qm=0, j=k=0, err=0, both counters 0. Consequently tgt_ready=1 and busy=0. Reset mid-operation discards queued and in-flight targets; no counter update.
- Push: on a clk edge where tgt_valid && tgt_ready, tgt_bit is written at wr_ptr. Pointers wrap modulo DEPTH. Full/empty tracked with an extra pointer bit or a count.
- Simultaneous push and pop in one cycle is legal when not full. When full, tgt_ready=0, so no push can coincide with a full FIFO.
- FSM states: IDLE, DRIVE, CHECK.
- IDLE, FIFO not empty, at edge E0:
  - pop head into tgt_r
  - register j/k from (qm, head)
  - go to DRIVE
- IDLE, FIFO empty: stay in IDLE, j=k=0.
- DRIVE: j/k are stable for this whole cycle. The downstream flip-flop samples them at edge E1. At E1: j<=0, k<=0, go to CHECK.
- CHECK, at edge E2:
  - compare q_fb with tgt_r; on mismatch set err=1 and increment err_count (saturating)
  - increment done_count
  - set qm<=q_fb (resynchronise to the real device, not to the target)
  - go to IDLE
- Throughput: one target per 3 cycles. Latency from push to done_count update is 3 cycles when the FIFO was empty and the FSM idle (push edge = E0 is not allowed; pop occurs on the edge after the push).
- Excitation, default encoding (don't-cares resolved to 0):
  - qm=0, t=0 -> j=0, k=0
  - qm=0, t=1 -> j=1, k=0
  - qm=1, t=0 -> j=0, k=1
  - qm=1, t=1 -> j=0, k=0
- j and k are never both 1 unless the optional feature below is compiled in.

Optional Feature:
Macro JK_TOGGLE_DRIVE_EN.
- Defined: every state change is driven as toggle, i.e. qm!=t -> j=1, k=1. qm==t -> j=0, k=0.
- Not defined: set/reset encoding as listed in Behaviour.
- Everything else (FSM, checking, counters) is identical in both builds.

Test Plan:
The bench instantiates a behavioural JK flip-flop (reset q=0, same active-low reset) fed by j/k, with its q driving q_fb, unless a scenario states otherwise.
1. Reset: hold rst=0, then release -> j=0, k=0, tgt_ready=1, busy=0, err=0, err_count=0, done_count=0.
2. Single push tgt_bit=1 -> exactly one DRIVE cycle with j=1, k=0. Then q_fb=1, done_count=1, err=0, busy returns to 0. With JK_TOGGLE_DRIVE_EN: j=1, k=1, same result.
3. Push sequence 1,1,0,0 -> DRIVE-cycle (j,k) = (1,0), (0,0), (0,1), (0,0). Final done_count=4, err=0, q_fb=0.
4. Push 8 bits back-to-back (1,0,1,0,1,0,1,0) with tgt_valid held high:
   - tgt_ready drops to 0 once DEPTH=4 entries are pending
   - no target is lost or duplicated
   - done_count=8, err=0
5. Stuck fault: q_fb tied to 0, push 1 -> err=1, err_count=1, qm=0. Then push 0 -> (j,k)=(0,0), err_count stays 1, done_count=2.
6. Async reset while in DRIVE with j=1: assert rst=0 between edges -> j=0 and k=0 immediately, FIFO empty, done_count=0. After release the next push behaves as in scenario 2.
